// File: rtl/cnn_layer_accel_awe_pkg.sv
// Shared declarations for the AWE per-job sequencer.
//   - default field widths (used as parameter defaults by the sequencer)
//   - awe_seq_state_t : sequencer FSM states
//   - awe_seq_cfg_t   : captured job configuration {kws, num_win, mode}
// The struct is sized from the package widths, so a width change is made here.
package cnn_layer_accel_awe_pkg;

  localparam int AWE_KERNAL_SIZE_WIDTH = 4;
  localparam int AWE_MODE_WIDTH        = 2;
  localparam int AWE_NUM_WIN_WIDTH     = 16;
  localparam int AWE_MAX_OUTSTANDING   = 64;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_LOAD  = 3'd1,
    SEQ_ISSUE = 3'd2,
    SEQ_DRAIN = 3'd3,
    SEQ_FIN   = 3'd4
  } awe_seq_state_t;

  typedef struct packed {
    logic [AWE_KERNAL_SIZE_WIDTH-1:0] kws;
    logic [AWE_NUM_WIN_WIDTH-1:0]     num_win;
    logic [AWE_MODE_WIDTH-1:0]        mode;
  } awe_seq_cfg_t;

endpackage

// File: rtl/cnn_layer_accel_awe_seq_cnt.sv
// Generic wrap-around counter with enable, terminal-count flag and
// synchronous clear. Used for the tap counter and the window counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear (job accept)
//   en         : advance by one; wraps to 0 when count == term_val
//   term_val   : terminal value (last count before wrap)
//   count      : current count
//   at_term    : count == term_val
module cnn_layer_accel_awe_seq_cnt
  import cnn_layer_accel_awe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             at_term
);

  assign at_term = (count == term_val);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_term ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cnn_layer_accel_awe_seq.sv
// Per-job sequencer for the two-CE AWE DSP chain.
// Accepts one job {K, num_windows, mode}, issues K*K operand strobes per
// window into the CE0/CE1 pixel/weight paths, counts returned results and
// pulses done once the job has drained.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   cfg_valid/cfg_ready       : job handshake (ready only in IDLE)
//   cfg_kernal_window_size    : K, taps per window = K*K
//   cfg_num_windows, cfg_mode : window count, datapath mode
//   buf_ready                 : operands for the current tap are available
//   issue_valid               : ce0/ce1 pixel_valid and weight_valid strobe
//   issue_tap_idx             : tap index within the window
//   issue_last_tap            : issue is the final tap of its window
//   new_map                   : pulse on the first issue of a job
//   kernal_window_size, mode  : registered configuration to the datapath
//   result_valid              : dataout_valid from the AWE DSP chain
//   busy, done                : status; done pulses one cycle in FIN
//   err_overrun               : sticky spurious-result flag (cleared by rst)
// Optional: define CNN_LAYER_ACCEL_AWE_SEQ_PERF_EN to add the
//   perf_busy_cycles / perf_stall_cycles saturating counters.
module cnn_layer_accel_awe_seq
  import cnn_layer_accel_awe_pkg::*;
#(
  parameter int C_KERNAL_SIZE_WIDTH = AWE_KERNAL_SIZE_WIDTH,
  parameter int C_MODE_WIDTH        = AWE_MODE_WIDTH,
  parameter int C_NUM_WIN_WIDTH     = AWE_NUM_WIN_WIDTH,
  parameter int C_MAX_OUTSTANDING   = AWE_MAX_OUTSTANDING
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [C_KERNAL_SIZE_WIDTH-1:0]   cfg_kernal_window_size,
  input  logic [C_NUM_WIN_WIDTH-1:0]       cfg_num_windows,
  input  logic [C_MODE_WIDTH-1:0]          cfg_mode,
  input  logic                             buf_ready,
  output logic                             issue_valid,
  output logic [2*C_KERNAL_SIZE_WIDTH-1:0] issue_tap_idx,
  output logic                             issue_last_tap,
  output logic                             new_map,
  output logic [C_KERNAL_SIZE_WIDTH-1:0]   kernal_window_size,
  output logic [C_MODE_WIDTH-1:0]          mode,
  input  logic                             result_valid,
  output logic                             busy,
  output logic                             done,
  output logic                             err_overrun
`ifdef CNN_LAYER_ACCEL_AWE_SEQ_PERF_EN
  ,
  output logic [31:0]                      perf_busy_cycles,
  output logic [31:0]                      perf_stall_cycles
`endif
);

  localparam int TW = 2 * C_KERNAL_SIZE_WIDTH;
  localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);

  function automatic logic [TW-1:0] taps_of(input logic [C_KERNAL_SIZE_WIDTH-1:0] k);
    return TW'(k) * TW'(k);
  endfunction

  awe_seq_state_t              state, state_nxt;
  awe_seq_cfg_t                cfg_q;
  logic [TW-1:0]               taps_q;
  logic [OW-1:0]               outstanding;
  logic [C_NUM_WIN_WIDTH-1:0]  returned;
  logic                        armed;
  logic [TW-1:0]               tap_cnt;
  logic                        tap_at_term;
  logic [C_NUM_WIN_WIDTH-1:0]  win_cnt;
  logic                        win_at_term;

  logic accept, issue_ok, last_issue, result_ok, spurious, degenerate;

  assign accept     = cfg_valid && (state == SEQ_IDLE);
  assign issue_ok   = (state == SEQ_ISSUE) && buf_ready &&
                      (outstanding < OW'(C_MAX_OUTSTANDING));
  assign last_issue = issue_ok && tap_at_term;
  assign result_ok  = result_valid && (state != SEQ_IDLE) && (outstanding != '0);
  // armed is cleared by rst and set on accept, so results still in flight
  // from a job aborted by reset do not raise the overrun flag.
  assign spurious   = result_valid && armed &&
                      ((state == SEQ_IDLE) || (outstanding == '0));
  assign degenerate = (cfg_q.kws == '0) || (cfg_q.num_win == '0);

  cnn_layer_accel_awe_seq_cnt #(.WIDTH(TW)) u_tap_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (issue_ok),
    .term_val (taps_q - TW'(1)),
    .count    (tap_cnt),
    .at_term  (tap_at_term)
  );

  cnn_layer_accel_awe_seq_cnt #(.WIDTH(C_NUM_WIN_WIDTH)) u_win_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (last_issue),
    .term_val (cfg_q.num_win - C_NUM_WIN_WIDTH'(1)),
    .count    (win_cnt),
    .at_term  (win_at_term)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      SEQ_IDLE:  if (cfg_valid) state_nxt = SEQ_LOAD;
      // Degenerate jobs still latch K/mode in LOAD, then skip ISSUE entirely.
      SEQ_LOAD:  state_nxt = degenerate ? SEQ_FIN : SEQ_ISSUE;
      SEQ_ISSUE: if (last_issue && win_at_term) state_nxt = SEQ_DRAIN;
      SEQ_DRAIN: if ((returned == cfg_q.num_win) && (outstanding == '0)) state_nxt = SEQ_FIN;
      SEQ_FIN:   state_nxt = SEQ_IDLE;
      default:   state_nxt = SEQ_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready      = (state == SEQ_IDLE);
    busy           = (state != SEQ_IDLE);
    done           = (state == SEQ_FIN);
    issue_valid    = issue_ok;
    issue_tap_idx  = tap_cnt;
    issue_last_tap = last_issue;
    // Tap 0 of window 0 occurs exactly once per job: after the final window
    // both counters wrap to 0 but the FSM has already left ISSUE.
    new_map        = issue_ok && (tap_cnt == '0) && (win_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= SEQ_IDLE;
      outstanding        <= '0;
      returned           <= '0;
      armed              <= 1'b0;
      err_overrun        <= 1'b0;
      kernal_window_size <= '0;
      mode               <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        returned <= '0;
        armed    <= 1'b1;
      end else if (result_ok) begin
        returned <= returned + C_NUM_WIN_WIDTH'(1);
      end
      if (state == SEQ_LOAD) begin
        kernal_window_size <= cfg_q.kws;
        mode               <= cfg_q.mode;
      end
      if (last_issue && !result_ok) begin
        outstanding <= outstanding + OW'(1);
      end else if (!last_issue && result_ok) begin
        outstanding <= outstanding - OW'(1);
      end
      if (spurious) begin
        err_overrun <= 1'b1;
      end
    end
  end

  // Configuration capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      cfg_q.kws     <= cfg_kernal_window_size;
      cfg_q.num_win <= cfg_num_windows;
      cfg_q.mode    <= cfg_mode;
    end
    if (state == SEQ_LOAD) begin
      taps_q <= taps_of(cfg_q.kws);
    end
  end

`ifdef CNN_LAYER_ACCEL_AWE_SEQ_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state != SEQ_IDLE) begin
        perf_busy_cycles <= sat_inc32(perf_busy_cycles);
      end
      if ((state == SEQ_ISSUE) && !issue_ok) begin
        perf_stall_cycles <= sat_inc32(perf_stall_cycles);
      end
    end
  end
`endif

endmodule
